ecc_correct_pipe: RTL and testbench
===================================

ECC_CORRECT_PIPE -- requirements
Module: ecc_correct_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of codeword and data buses.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  codeword and syndrome on inputs are valid.
REQ-005 in_ready  output  1  block accepts the input this cycle.
REQ-006 NoisyCodeWord  input  DATA_WIDTH  received codeword; low 8 or 16 bits significant.
REQ-007 Codeword_Width  input  2  0 = 8-bit mode; 1, 2 or 3 = 16-bit mode, same as the upstream syndrome stage.
REQ-008 column  input  5  syndrome from the upstream syndrome stage for the same codeword.
REQ-009 out_valid  output  1  corrected result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 data_out  output  DATA_WIDTH  corrected codeword, zero-extended above the mode width.
REQ-012 num_of_errors  output  2  0 = none, 1 = single corrected, 2 = double detected (uncorrectable), 3 never driven.

Function
REQ-013 The block SHALL be a 2-stage valid/ready pipeline: S1 registers inputs; S2 holds the corrected result and error class.
REQ-014 A transfer SHALL occur on any cycle with valid && ready on a port; a word accepted at edge N SHALL present out_valid at edge N+2 when out_ready stays high.
REQ-015 in_ready SHALL equal !S1_full || S2 advancing (S2 empty, or out_ready high); S1 SHALL advance into S2 under the same condition.
REQ-016 With out_ready low and both stages full, in_ready SHALL be 0 and data_out/num_of_errors SHALL hold stable.
REQ-017 Simultaneous accept at S1 and drain of S2 in one cycle SHALL lose no word and duplicate no word; sustained throughput SHALL be one word per cycle.
REQ-018 8-bit mode: parity bit p = column[3], position s = column[2:0]; 16-bit mode: p = column[4], s = column[3:0].
REQ-019 p=0, s=0 -> num_of_errors=0, data_out = codeword unchanged.
REQ-020 p=1 -> num_of_errors=1; flip the bit whose H column equals s (s=0 selects the overall parity bit: bit 3 in 8-bit mode, bit 4 in 16-bit mode).
REQ-021 H1 columns, bit7..bit0: 111,110,101,011,000,100,010,001; H2 column for bit i SHALL match the upstream 16-bit equations.
REQ-022 p=0, s!=0 -> num_of_errors=2, data_out = codeword unchanged.
REQ-023 p=1 with s matching no column -> num_of_errors=2, no bit flipped.
REQ-024 Bits of NoisyCodeWord above the mode width SHALL be ignored and driven 0 on data_out.

Reset
REQ-025 With rst high at a clock edge, both stages SHALL empty, out_valid=0, data_out=0, num_of_errors=0, and in_ready=0 for that cycle.
REQ-026 Reset mid-stream SHALL discard in-flight words with no partial output; in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-027 Macro ECC_STATS_EN defined: add outputs corr_cnt[15:0] and uncorr_cnt[15:0], incremented on each output transfer with class 1 or 2 respectively, saturating at 16'hFFFF, cleared by rst.
REQ-028 Macro ECC_STATS_EN undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package ecc_pkg SHALL hold the H1/H2 column tables, mode encodings, the error-class enum (NO_ERR, SINGLE, DOUBLE), and the parity-bit position constants.
REQ-030 Sub-module ecc_bit_locator (combinational: mode, syndrome -> one-hot flip mask plus error class) SHALL be instantiated in S2.

Verification
REQ-031 8-bit, codeword 8'hA5, column 5'b00000 -> after 2 cycles data_out=8'hA5, num_of_errors=0.
REQ-032 8-bit, codeword 8'hA5 with bit 6 flipped (8'hE5), column 5'b01110 -> data_out=8'hA5, num_of_errors=1.
REQ-033 8-bit, column 5'b00011 (p=0, s!=0) -> data_out=input, num_of_errors=2.
REQ-034 16-bit, every single-bit flip of 16'h0000 with matching syndrome -> data_out=16'h0000, num_of_errors=1.
REQ-035 Back-to-back 10 words with out_ready toggled 1,0,0,1,... -> order preserved, no loss or duplication, outputs stable while stalled.
REQ-036 rst asserted with both stages full -> next cycle out_valid=0, data_out=0, then in_ready=1.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg
//   Shared definitions for the ECC correction pipeline: codeword mode
//   encoding, error-class enum, parity-bit positions and the parity-check
//   (H) column tables for the 8-bit and 16-bit SEC-DED codes.
//
//   H1 (8-bit): column per codeword bit, bit7..bit0.
//   H2 (16-bit): check bits sit at bits 3..0 (one-hot columns), the overall
//   parity bit at bit 4 (column 0), and data bits 15..5 take the remaining
//   weight>=2 columns in descending order. This matches the upstream
//   syndrome stage.
package ecc_pkg;

  // Codeword_Width encoding: 0 selects 8-bit mode, anything else 16-bit.
  localparam logic [1:0] MODE_8 = 2'd0;

  localparam int CW_W8  = 8;
  localparam int CW_W16 = 16;

  // Overall-parity bit position, selected by a zero syndrome with p=1.
  localparam int PAR_POS_8  = 3;
  localparam int PAR_POS_16 = 4;

  typedef enum logic [1:0] {
    NO_ERR = 2'd0,
    SINGLE = 2'd1,
    DOUBLE = 2'd2
  } err_class_e;

  // Element [i] is the H column of codeword bit i.
  localparam logic [7:0][2:0] H1_COLS = {
    3'b111, 3'b110, 3'b101, 3'b011, 3'b000, 3'b100, 3'b010, 3'b001
  };

  localparam logic [15:0][3:0] H2_COLS = {
    4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h7,
    4'h6, 4'h5, 4'h3, 4'h0, 4'h8, 4'h4, 4'h2, 4'h1
  };

  function automatic logic is_mode8(input logic [1:0] mode);
    return (mode == MODE_8);
  endfunction

  function automatic int mode_width(input logic [1:0] mode);
    return is_mode8(mode) ? CW_W8 : CW_W16;
  endfunction

endpackage

// File: rtl/ecc_bit_locator.sv
// ecc_bit_locator
//   Combinational decode of a SEC-DED syndrome into a one-hot flip mask and
//   an error class.
//
// Ports
//   mode       in   2   codeword mode (0 = 8-bit, else 16-bit)
//   column     in   5   syndrome: 8-bit p=[3], s=[2:0]; 16-bit p=[4], s=[3:0]
//   flip_mask  out  16  one-hot bit to invert (all zero when nothing flips)
//   err_class  out  2   NO_ERR / SINGLE / DOUBLE
module ecc_bit_locator
  import ecc_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [4:0]  column,
  output logic [15:0] flip_mask,
  output err_class_e  err_class
);

  logic        par;
  logic [3:0]  syn;
  logic [15:0] match;

  always_comb begin
    par   = 1'b0;
    syn   = 4'd0;
    match = '0;
    if (is_mode8(mode)) begin
      par = column[3];
      syn = {1'b0, column[2:0]};
      for (int i = 0; i < CW_W8; i++) begin
        if (i != PAR_POS_8 && syn[2:0] == H1_COLS[i]) match[i] = 1'b1;
      end
      if (syn == 4'd0) match[PAR_POS_8] = 1'b1;
    end else begin
      par = column[4];
      syn = column[3:0];
      for (int i = 0; i < CW_W16; i++) begin
        if (i != PAR_POS_16 && syn == H2_COLS[i]) match[i] = 1'b1;
      end
      if (syn == 4'd0) match[PAR_POS_16] = 1'b1;
    end
  end

  // Only an odd overall parity permits a correction; an even parity with a
  // non-zero syndrome, or an odd parity pointing at no column, is a double.
  always_comb begin
    flip_mask = '0;
    err_class = NO_ERR;
    if (par) begin
      if (match != '0) begin
        flip_mask = match;
        err_class = SINGLE;
      end else begin
        err_class = DOUBLE;
      end
    end else if (syn != 4'd0) begin
      err_class = DOUBLE;
    end
  end

endmodule

// File: rtl/ecc_correct_pipe.sv
// ecc_correct_pipe
//   Two-stage valid/ready SEC-DED correction pipeline. Stage 1 registers the
//   received codeword (trimmed to the mode width), mode and syndrome. Stage 2
//   holds the corrected codeword and the error class. One word per cycle
//   sustained; both stages hold while the downstream stalls.
//
// Ports
//   clk            in   1           clock, rising edge
//   rst            in   1           synchronous active-high reset
//   in_valid       in   1           input word valid
//   in_ready       out  1           input accepted this cycle
//   NoisyCodeWord  in   DATA_WIDTH  received codeword (low 8/16 bits used)
//   Codeword_Width in   2           0 = 8-bit, 1..3 = 16-bit
//   column         in   5           syndrome for this codeword
//   out_valid      out  1           corrected result valid
//   out_ready      in   1           downstream accepts result
//   data_out       out  DATA_WIDTH  corrected codeword, zero-extended
//   num_of_errors  out  2           0 none, 1 corrected, 2 uncorrectable
//   corr_cnt       out  16          (ECC_STATS_EN only) corrected-word count
//   uncorr_cnt     out  16          (ECC_STATS_EN only) uncorrectable count
//
// Build option: define ECC_STATS_EN to add the saturating statistics
// counters.
module ecc_correct_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] NoisyCodeWord,
  input  logic [1:0]            Codeword_Width,
  input  logic [4:0]            column,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
`ifdef ECC_STATS_EN
  output logic [15:0]           corr_cnt,
  output logic [15:0]           uncorr_cnt,
`endif
  output logic [1:0]            num_of_errors
);

  function automatic logic [DATA_WIDTH-1:0] trim_cw(
    input logic [DATA_WIDTH-1:0] cw,
    input logic [1:0]            mode
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < mode_width(mode)) r[i] = cw[i];
    end
    return r;
  endfunction

`ifdef ECC_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] cw_p1;
  logic [1:0]            mode_p1;
  logic [4:0]            col_p1;

  logic                  vld_p2;
  logic [DATA_WIDTH-1:0] data_p2;
  err_class_e            err_p2;

  logic                  adv_p2;
  logic                  accept;
  logic [15:0]           flip_mask;
  err_class_e            err_class;

  // S2 can take a new word when empty or when its word leaves this cycle.
  assign adv_p2   = !vld_p2 || out_ready;
  assign in_ready = !rst && (!vld_p1 || adv_p2);
  assign accept   = in_valid && in_ready;

  // ---- stage 1: input capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cw_p1   <= trim_cw(NoisyCodeWord, Codeword_Width);
      mode_p1 <= Codeword_Width;
      col_p1  <= column;
    end
  end

  ecc_bit_locator u_locator (
    .mode      (mode_p1),
    .column    (col_p1),
    .flip_mask (flip_mask),
    .err_class (err_class)
  );

  // ---- stage 2: corrected result ----
  // Output data is cleared by reset so nothing stale is visible afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      err_p2  <= NO_ERR;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= cw_p1 ^ DATA_WIDTH'(flip_mask);
        err_p2  <= err_class;
      end
    end
  end

  assign out_valid     = vld_p2;
  assign data_out      = data_p2;
  assign num_of_errors = err_p2;

`ifdef ECC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt   <= 16'd0;
      uncorr_cnt <= 16'd0;
    end else if (vld_p2 && out_ready) begin
      if (err_p2 == SINGLE) corr_cnt   <= sat_inc(corr_cnt);
      if (err_p2 == DOUBLE) uncorr_cnt <= sat_inc(uncorr_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ecc_correct_pipe.sv
// tb_ecc_correct_pipe
//   Directed, table-driven bench for ecc_correct_pipe (DATA_WIDTH = 32),
//   plus hand-written sequences for stall, stream ordering and reset.
module tb_ecc_correct_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] NoisyCodeWord;
  logic [1:0]  Codeword_Width;
  logic [4:0]  column;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
`ifdef ECC_STATS_EN
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  ecc_correct_pipe #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .NoisyCodeWord  (NoisyCodeWord),
    .Codeword_Width (Codeword_Width),
    .column         (column),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_out       (data_out),
`ifdef ECC_STATS_EN
    .corr_cnt       (corr_cnt),
    .uncorr_cnt     (uncorr_cnt),
`endif
    .num_of_errors  (num_of_errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] cw;
    logic [4:0]  col;
    logic [31:0] exp_d;
    logic [1:0]  exp_e;
  } vec_t;

  vec_t vecs[11];

  // 16-bit H columns, written out independently of the design package.
  function automatic logic [3:0] h2col(input int i);
    case (i)
      0: return 4'h1;   1: return 4'h2;   2: return 4'h4;   3: return 4'h8;
      4: return 4'h0;   5: return 4'h3;   6: return 4'h5;   7: return 4'h6;
      8: return 4'h7;   9: return 4'h9;  10: return 4'hA;  11: return 4'hB;
     12: return 4'hC;  13: return 4'hD;  14: return 4'hE;
      default: return 4'hF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send_one(input string nm, input logic [1:0] m, input logic [31:0] cw,
                          input logic [4:0] col, input logic [31:0] exp_d,
                          input logic [1:0] exp_e);
    int n;
    @(negedge clk);
    in_valid       = 1'b1;
    Codeword_Width = m;
    NoisyCodeWord  = cw;
    column         = col;
    out_ready      = 1'b1;
    #1 chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    NoisyCodeWord = 32'hFFFF_FFFF;
    column        = 5'h1F;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({nm, " timeout"}, {31'd0, out_valid}, 32'd1);
    end else begin
      chk({nm, " latency"}, n, 32'd1);
      chk({nm, " data"}, data_out, exp_d);
      chk({nm, " err"}, {30'd0, num_of_errors}, {30'd0, exp_e});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_q[10];
    logic [31:0] held_d;
    logic        held;
    int          sent, got, extra;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    NoisyCodeWord = '0; Codeword_Width = 2'd0; column = '0;

    repeat (3) @(negedge clk);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst data_out", data_out, 32'd0);
    chk("rst num_err", {30'd0, num_of_errors}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    vecs[0]  = '{"v8 clean",      2'd0, 32'h0000_00A5, 5'b00000, 32'h0000_00A5, 2'd0};
    vecs[1]  = '{"v8 bit6",       2'd0, 32'h0000_00E5, 5'b01110, 32'h0000_00A5, 2'd1};
    vecs[2]  = '{"v8 double",     2'd0, 32'h0000_00A5, 5'b00011, 32'h0000_00A5, 2'd2};
    vecs[3]  = '{"v8 upper",      2'd0, 32'hDEAD_12A5, 5'b00000, 32'h0000_00A5, 2'd0};
    vecs[4]  = '{"v8 parbit",     2'd0, 32'h0000_0008, 5'b01000, 32'h0000_0000, 2'd1};
    vecs[5]  = '{"v8 ignore c4",  2'd0, 32'h0000_00A5, 5'b10000, 32'h0000_00A5, 2'd0};
    vecs[6]  = '{"v8 bit0",       2'd0, 32'h0000_00A4, 5'b01001, 32'h0000_00A5, 2'd1};
    vecs[7]  = '{"v16 clean",     2'd1, 32'hFFFF_1234, 5'b00000, 32'h0000_1234, 2'd0};
    vecs[8]  = '{"v16 double",    2'd2, 32'h0000_1234, 5'b00110, 32'h0000_1234, 2'd2};
    vecs[9]  = '{"v16 bit15",     2'd3, 32'h0000_9234, 5'b11111, 32'h0000_1234, 2'd1};
    vecs[10] = '{"v16 parbit",    2'd1, 32'h0000_0010, 5'b10000, 32'h0000_0000, 2'd1};

    for (int i = 0; i < 11; i++)
      send_one(vecs[i].name, vecs[i].mode, vecs[i].cw, vecs[i].col,
               vecs[i].exp_d, vecs[i].exp_e);

    for (int i = 0; i < 16; i++)
      send_one($sformatf("v16 flip%0d", i), 2'd1, 32'd1 << i,
               {1'b1, h2col(i)}, 32'd0, 2'd1);

    // Stream of ten corrected words under a 1,0,0,1 out_ready pattern.
    for (int k = 0; k < 10; k++) exp_q[k] = 32'h1000 + k * 32'h0111;
    sent = 0; got = 0; held = 1'b0; held_d = '0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 10);
      Codeword_Width = 2'd1;
      if (sent < 10) begin
        NoisyCodeWord = exp_q[sent] ^ (32'd1 << sent);
        column        = {1'b1, h2col(sent)};
      end
      #1;
      if (held) begin
        chk("stall out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall data", data_out, held_d);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream data%0d", got), data_out, exp_q[got]);
        chk($sformatf("stream err%0d", got), {30'd0, num_of_errors}, 32'd1);
        got++;
      end
      held   = out_valid && !out_ready;
      held_d = data_out;
      if (in_valid && in_ready) sent++;
    end
    chk("stream count", got, 32'd10);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream extra", extra, 32'd0);

    // Fill both stages with downstream stalled, then reset.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; Codeword_Width = 2'd0;
    NoisyCodeWord = 32'h0000_00A5; column = 5'b00000;
    @(negedge clk);
    NoisyCodeWord = 32'h0000_005A;
    #1 chk("fill in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full out_valid", {31'd0, out_valid}, 32'd1);
    chk("full in_ready", {31'd0, in_ready}, 32'd0);
    chk("full data", data_out, 32'h0000_00A5);
    @(negedge clk);
    chk("full hold data", data_out, 32'h0000_00A5);
    chk("full hold err", {30'd0, num_of_errors}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid-rst data", data_out, 32'd0);
    chk("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    #1 chk("after-rst in_ready", {31'd0, in_ready}, 32'd1);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("after-rst no output", extra, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
